// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a little-endian byte stream (count, words, checksum)
// into 32-bit writes and holds the CPU in reset until a verified image is in memory.
module imem_loader #(
    parameter logic [31:0] BaseAddr = 32'h0000_0000,
    parameter int unsigned MaxWords = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    input  logic        load_req_i,
    output logic        imem_we_o,
    output logic [31:0] imem_addr_o,
    output logic [31:0] imem_wdata_o,
    output logic        cpu_rst_o,
    output logic        done_o,
    output logic        error_o
);

    localparam int unsigned IdxW = $clog2(MaxWords + 1);

    typedef enum logic [2:0] {
        StHdr,
        StData,
        StChk,
        StDone,
        StErr
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    // Holds the three most recent bytes of the field being collected.
    logic [23:0]       shift_q, shift_d;
    logic [IdxW-1:0]   count_q, count_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [31:0]       sum_q, sum_d;
    logic              imem_we_q, imem_we_d;
    logic [31:0]       imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              accept;
    logic              field_done;
    logic [31:0]       word_next;
    logic [31:0]       word_addr;

    assign rx_ready_o = (state_q == StHdr) || (state_q == StData) || (state_q == StChk);

    assign accept     = rx_valid_i && rx_ready_o;
    assign field_done = accept && (byte_cnt_q == 2'd3);
    assign word_next  = {rx_data_i, shift_q};
    assign word_addr  = BaseAddr + (32'(idx_q) << 2);

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        shift_d      = shift_q;
        count_d      = count_q;
        idx_d        = idx_q;
        sum_d        = sum_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        cpu_rst_d    = cpu_rst_q;
        done_d       = done_q;
        error_d      = error_q;

        if (accept) begin
            shift_d    = word_next[31:8];
            byte_cnt_d = byte_cnt_q + 2'd1;
        end

        unique case (state_q)
            StHdr: begin
                if (field_done) begin
                    idx_d   = '0;
                    sum_d   = '0;
                    count_d = word_next[IdxW-1:0];
                    if (word_next > 32'(MaxWords)) begin
                        state_d = StErr;
                        error_d = 1'b1;
                    end else if (word_next == 32'd0) begin
                        state_d = StChk;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (field_done) begin
                    imem_we_d    = 1'b1;
                    imem_wdata_d = word_next;
                    imem_addr_d  = word_addr;
                    idx_d        = idx_q + 1'b1;
                    sum_d        = sum_q + word_next;
                    if (idx_q == count_q - 1'b1) begin
                        state_d = StChk;
                    end
                end
            end
            StChk: begin
                if (field_done) begin
                    if (word_next == sum_q) begin
                        state_d   = StDone;
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b0;
                    end else begin
                        state_d = StErr;
                        error_d = 1'b1;
                    end
                end
            end
            StDone, StErr: begin
                if (load_req_i) begin
                    state_d    = StHdr;
                    byte_cnt_d = '0;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    cpu_rst_d  = 1'b1;
                end
            end
            default: begin
                state_d = StHdr;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StHdr;
            byte_cnt_q   <= '0;
            shift_q      <= '0;
            count_q      <= '0;
            idx_q        <= '0;
            sum_q        <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= BaseAddr;
            imem_wdata_q <= '0;
            cpu_rst_q    <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            shift_q      <= shift_d;
            count_q      <= count_d;
            idx_q        <= idx_d;
            sum_q        <= sum_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_rst_q    <= cpu_rst_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign imem_we_o    = imem_we_q;
    assign imem_addr_o  = imem_addr_q;
    assign imem_wdata_o = imem_wdata_q;
    assign cpu_rst_o    = cpu_rst_q;
    assign done_o       = done_q;
    assign error_o      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good/bad images, size limits, gaps, reset and reload.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        load_req = 1'b0;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    logic [7:0]  img[$];
    logic [31:0] wa[$];
    logic [31:0] wd[$];

    imem_loader dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .rx_data_i    (rx_data),
        .rx_valid_i   (rx_valid),
        .rx_ready_o   (rx_ready),
        .load_req_i   (load_req),
        .imem_we_o    (imem_we),
        .imem_addr_o  (imem_addr),
        .imem_wdata_o (imem_wdata),
        .cpu_rst_o    (cpu_rst),
        .done_o       (done),
        .error_o      (error)
    );

    always #5 clk = ~clk;

    // Each registered write pulse is seen exactly once per cycle it is high.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wa.push_back(imem_addr);
            wd.push_back(imem_wdata);
        end
    end

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) img.push_back(w[8*i +: 8]);
    endtask

    task automatic build_n2(input logic [7:0] chk0);
        img.delete();
        push_word(32'd2);
        push_word(32'h0050_0513);
        push_word(32'h0000_006F);
        push_word({24'h005005, chk0});
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        if (gap > 0) begin
            rx_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (rx_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL byte_accept timeout rx_ready=%b want 1", rx_ready);
            rx_valid = 1'b0;
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic send_range(input int from, input int to, input int max_gap);
        for (int i = from; i < to; i++)
            send_byte(img[i], (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
    endtask

    task automatic pulse_load_req();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        checks++;
        if ({cpu_rst, done, error, rx_ready} !== 4'b1001) begin
            errors++;
            $display("FAIL load_req_restart {cpu_rst,done,error,rx_ready}=%b want 1001",
                     {cpu_rst, done, error, rx_ready});
        end
    endtask

    task automatic load_n2_ok(input string tag, input int max_gap);
        build_n2(8'h82);
        wa.delete();
        wd.delete();
        send_range(0, 15, max_gap);
        checks++;
        if (done !== 1'b0 || cpu_rst !== 1'b1) begin
            errors++;
            $display("FAIL %s pre_last done=%b cpu_rst=%b want 0 1", tag, done, cpu_rst);
        end
        send_range(15, 16, max_gap);
        rx_valid = 1'b0;
        checks++;
        if ({done, cpu_rst, error, rx_ready} !== 4'b1000) begin
            errors++;
            $display("FAIL %s final {done,cpu_rst,error,rx_ready}=%b want 1000",
                     tag, {done, cpu_rst, error, rx_ready});
        end
        checks++;
        if (wa.size() !== 2) begin
            errors++;
            $display("FAIL %s write_count got %0d want 2", tag, wa.size());
        end else begin
            checks++;
            if (wa[0] !== 32'h0 || wd[0] !== 32'h0050_0513) begin
                errors++;
                $display("FAIL %s write0 got %h/%h want 00000000/00500513", tag, wa[0], wd[0]);
            end
            checks++;
            if (wa[1] !== 32'h4 || wd[1] !== 32'h0000_006F) begin
                errors++;
                $display("FAIL %s write1 got %h/%h want 00000004/0000006f", tag, wa[1], wd[1]);
            end
        end
        checks++;
        if (imem_we !== 1'b0 || imem_addr !== 32'h4 || imem_wdata !== 32'h6F) begin
            errors++;
            $display("FAIL %s hold we=%b addr=%h data=%h want 0 00000004 0000006f",
                     tag, imem_we, imem_addr, imem_wdata);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({cpu_rst, done, error, rx_ready, imem_we} !== 5'b10010) begin
            errors++;
            $display("FAIL reset {cpu_rst,done,error,rx_ready,we}=%b want 10010",
                     {cpu_rst, done, error, rx_ready, imem_we});
        end
        checks++;
        if (imem_addr !== 32'h0 || imem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus addr=%h data=%h want 0 0", imem_addr, imem_wdata);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_load_n2();
        load_n2_ok("n2", 0);
    endtask

    task automatic test_bad_checksum();
        pulse_load_req();
        build_n2(8'h83);
        wa.delete();
        wd.delete();
        send_range(0, 16, 0);
        rx_valid = 1'b0;
        checks++;
        if ({error, cpu_rst, done, rx_ready} !== 4'b1100) begin
            errors++;
            $display("FAIL bad_chk {error,cpu_rst,done,rx_ready}=%b want 1100",
                     {error, cpu_rst, done, rx_ready});
        end
        checks++;
        if (wa.size() !== 2) begin
            errors++;
            $display("FAIL bad_chk write_count got %0d want 2", wa.size());
        end
        rx_data  = 8'h00;
        rx_valid = 1'b1;
        repeat (4) @(negedge clk);
        rx_valid = 1'b0;
        checks++;
        if ({error, done, rx_ready, imem_we} !== 4'b1000 || wa.size() !== 2) begin
            errors++;
            $display("FAIL err_sticky {error,done,rx_ready,we}=%b writes=%0d want 1000 2",
                     {error, done, rx_ready, imem_we}, wa.size());
        end
    endtask

    task automatic test_zero_len();
        pulse_load_req();
        img.delete();
        push_word(32'd0);
        push_word(32'd0);
        wa.delete();
        wd.delete();
        send_range(0, 8, 0);
        rx_valid = 1'b0;
        checks++;
        if ({done, error, cpu_rst} !== 3'b100 || wa.size() !== 0) begin
            errors++;
            $display("FAIL zero_len {done,error,cpu_rst}=%b writes=%0d want 100 0",
                     {done, error, cpu_rst}, wa.size());
        end
    endtask

    task automatic test_oversize();
        pulse_load_req();
        img.delete();
        push_word(32'h0000_0401);
        wa.delete();
        wd.delete();
        send_range(0, 4, 0);
        rx_valid = 1'b0;
        checks++;
        if ({error, done, cpu_rst, rx_ready} !== 4'b1010 || wa.size() !== 0) begin
            errors++;
            $display("FAIL oversize {error,done,cpu_rst,rx_ready}=%b writes=%0d want 1010 0",
                     {error, done, cpu_rst, rx_ready}, wa.size());
        end
    endtask

    task automatic test_back_to_back();
        pulse_load_req();
        load_n2_ok("b2b", 0);
        pulse_load_req();
        load_n2_ok("gaps", 5);
    endtask

    task automatic test_reset_midload();
        pulse_load_req();
        build_n2(8'h82);
        wa.delete();
        wd.delete();
        send_range(0, 10, 0);
        rx_valid = 1'b0;
        checks++;
        if (wa.size() !== 1) begin
            errors++;
            $display("FAIL midload write_count got %0d want 1", wa.size());
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({cpu_rst, rx_ready, done, imem_we} !== 4'b1100 || imem_addr !== 32'h0
            || imem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL midload_rst {cpu_rst,rx_ready,done,we}=%b addr=%h data=%h want 1100 0 0",
                     {cpu_rst, rx_ready, done, imem_we}, imem_addr, imem_wdata);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        load_n2_ok("after_rst", 0);
    endtask

    task automatic test_load_req_after_done();
        load_req = 1'b1;
        #1;
        checks++;
        if (done !== 1'b1 || cpu_rst !== 1'b0) begin
            errors++;
            $display("FAIL reload_pre done=%b cpu_rst=%b want 1 0", done, cpu_rst);
        end
        @(negedge clk);
        load_req = 1'b0;
        checks++;
        if ({done, cpu_rst, rx_ready} !== 3'b011) begin
            errors++;
            $display("FAIL reload {done,cpu_rst,rx_ready}=%b want 011",
                     {done, cpu_rst, rx_ready});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_n2();
        test_bad_checksum();
        test_zero_len();
        test_oversize();
        test_back_to_back();
        test_reset_midload();
        test_load_req_after_done();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
